// File: rtl/fifo_unpacker.sv
// fifo_unpacker: drains show-ahead FIFO words into LWIDTH-bit lanes on a valid/ready stream.
// Build option: define FIFO_UNPACK_MSB_FIRST_EN to emit the most-significant lane first.
module fifo_unpacker #(
  parameter int DWIDTH = 40,
  parameter int LWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DWIDTH-1:0]    fifo_rd,
  output logic                 fifo_rden,
  input  logic                 flush,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [LWIDTH-1:0]    o_data,
  output logic [(((DWIDTH/LWIDTH) > 1) ? $clog2(DWIDTH/LWIDTH) : 1)-1:0] o_lane,
  output logic                 o_last
);

  localparam int NLANE  = DWIDTH / LWIDTH;
  localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DWIDTH-1:0]   r_word;
  logic [DWIDTH-1:0]   w_word_nxt;
  logic [LANE_W-1:0]   r_lane;
  logic [LANE_W-1:0]   w_lane_nxt;
  logic                w_busy;
  logic                w_last;
  logic                w_acc;
  logic                w_fin;
  logic                w_pop;
  logic [LWIDTH-1:0]   w_lanes [NLANE];

  assign w_busy = (r_state == DRAIN);
  assign w_last = w_busy & (r_lane == LAST_LANE);
  assign w_acc  = w_busy & o_ready;
  assign w_fin  = w_acc & w_last;
  // Pop only when the held word is absent or finishing this cycle; no dependence on fifo_rd.
  assign w_pop  = ~rst & ~flush & ~fifo_empty & (~w_busy | w_fin);

  assign fifo_rden = w_pop;
  assign o_valid   = w_busy;
  assign o_lane    = r_lane;
  assign o_last    = w_last;
  assign o_data    = w_lanes[r_lane];

  // Lane slicing of the held word in emission order.
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      w_lanes[i] = r_word[DWIDTH-1-i*LWIDTH -: LWIDTH];
`else
      w_lanes[i] = r_word[i*LWIDTH +: LWIDTH];
`endif
    end
  end

  // Next-state: flush beats everything; a pop on word end reloads without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_lane_nxt  = r_lane;
    if (flush) begin
      w_state_nxt = IDLE;
      w_lane_nxt  = '0;
    end else if (w_pop) begin
      w_state_nxt = DRAIN;
      w_word_nxt  = fifo_rd;
      w_lane_nxt  = '0;
    end else if (w_fin) begin
      w_state_nxt = IDLE;
      w_lane_nxt  = '0;
    end else if (w_acc) begin
      w_lane_nxt  = r_lane + LANE_W'(1);
    end else begin
      w_lane_nxt  = r_lane;
    end
  end

  // State, word and lane registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: directed scenarios plus randomized traffic
// checked against a queue-based model of the lane stream.
module tb_fifo_unpacker;

  localparam int DW = 40;
  localparam int LW = 8;
  localparam int NL = DW / LW;
  localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;

  typedef struct {
    logic [LW-1:0] d;
    int            lane;
    bit            last;
  } lane_t;

  logic              clk;
  logic              rst;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_rd;
  logic              fifo_rden;
  logic              flush;
  logic              o_valid;
  logic              o_ready;
  logic [LW-1:0]     o_data;
  logic [LANE_W-1:0] o_lane;
  logic              o_last;

  logic [DW-1:0] fq [$];
  lane_t         pend [$];

  int vecs = 0;
  int errs = 0;

  logic          obs_valid, obs_last, obs_rden;
  logic [LW-1:0] obs_data;
  int            obs_lane;
  logic          exp_valid, exp_last, exp_rden;
  logic [LW-1:0] exp_data;
  int            exp_lane;

  fifo_unpacker #(.DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rden  (fifo_rden),
    .flush      (flush),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_lane     (o_lane),
    .o_last     (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lane_of(input logic [DW-1:0] w, input int i);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return LW'(w >> (DW - LW * (i + 1)));
`else
    return LW'(w >> (LW * i));
`endif
  endfunction

  function automatic logic [LW-1:0] known_lane(input int i);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return LW'(NL - i);
`else
    return LW'(i + 1);
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // One cycle: drive inputs, sample outputs, compute model expectations, advance the model.
  task automatic tick(input bit rdy, input bit fl, input bit rs);
    logic [DW-1:0] w;
    lane_t e;
    @(negedge clk);
    o_ready    = rdy;
    flush      = fl;
    rst        = rs;
    fifo_empty = (fq.size() == 0);
    fifo_rd    = (fq.size() != 0) ? fq[0] : rnd_word();
    #1;
    obs_valid = o_valid;
    obs_data  = o_data;
    obs_lane  = int'(o_lane);
    obs_last  = o_last;
    obs_rden  = fifo_rden;
    exp_valid = (pend.size() != 0);
    exp_data  = exp_valid ? pend[0].d : '0;
    exp_lane  = exp_valid ? pend[0].lane : 0;
    exp_last  = exp_valid ? pend[0].last : 1'b0;
    exp_rden  = !rs && !fl && (fq.size() != 0) &&
                ((pend.size() == 0) || ((pend.size() == 1) && rdy));
    if (rs || fl) begin
      pend.delete();
    end else begin
      if (exp_valid && rdy) pend.delete(0);
      if (exp_rden) begin
        w = fq.pop_front();
        for (int i = 0; i < NL; i++) begin
          e.d = lane_of(w, i);
          e.lane = i;
          e.last = (i == NL - 1);
          pend.push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 64 && (pend.size() != 0 || fq.size() != 0); c++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    vecs++; if (obs_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 00", obs_data); end
    vecs++; if (obs_lane !== 0) begin errs++; $display("FAIL reset_lane: got %0d want 0", obs_lane); end
    vecs++; if (obs_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b want 0", obs_last); end
    vecs++; if (obs_rden !== 1'b0) begin errs++; $display("FAIL reset_rden: got %b want 0", obs_rden); end
    tick(1'b0, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL idle_valid: got %b want 0", obs_valid); end
  endtask

  task automatic test_single_word();
    fq.push_back(40'h05_04_03_02_01);
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_rden !== 1'b1) begin errs++; $display("FAIL single_pop: got %b want 1", obs_rden); end
    vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL single_pre_valid: got %b want 0", obs_valid); end
    for (int i = 0; i < NL; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      vecs++; if (obs_valid !== 1'b1) begin errs++; $display("FAIL single_valid[%0d]: got %b want 1", i, obs_valid); end
      vecs++; if (obs_data !== known_lane(i)) begin errs++; $display("FAIL single_data[%0d]: got %h want %h", i, obs_data, known_lane(i)); end
      vecs++; if (obs_lane !== i) begin errs++; $display("FAIL single_lane[%0d]: got %0d want %0d", i, obs_lane, i); end
      vecs++; if (obs_last !== (i == NL - 1)) begin errs++; $display("FAIL single_last[%0d]: got %b want %b", i, obs_last, (i == NL - 1)); end
      vecs++; if (obs_rden !== 1'b0) begin errs++; $display("FAIL single_rden[%0d]: got %b want 0", i, obs_rden); end
    end
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL single_post_valid: got %b want 0", obs_valid); end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0, run = 0, maxrun = 0, nrden = 0;
    for (int k = 0; k < 3; k++) fq.push_back(rnd_word());
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      vecs++; if (obs_valid !== exp_valid) begin errs++; $display("FAIL b2b_valid c%0d: got %b want %b", c, obs_valid, exp_valid); end
      vecs++; if (obs_rden !== exp_rden) begin errs++; $display("FAIL b2b_rden c%0d: got %b want %b", c, obs_rden, exp_rden); end
      if (exp_valid) begin
        vecs++; if (obs_data !== exp_data) begin errs++; $display("FAIL b2b_data c%0d: got %h want %h", c, obs_data, exp_data); end
      end
      if (obs_valid === 1'b1) begin nvalid++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      if (obs_rden === 1'b1) nrden++;
    end
    vecs++; if (nvalid != 3 * NL) begin errs++; $display("FAIL b2b_count: got %0d want %0d", nvalid, 3 * NL); end
    vecs++; if (maxrun != 3 * NL) begin errs++; $display("FAIL b2b_run: got %0d want %0d", maxrun, 3 * NL); end
    vecs++; if (nrden != 3) begin errs++; $display("FAIL b2b_pops: got %0d want 3", nrden); end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] held;
    held = '0;
    fq.push_back(rnd_word());
    fq.push_back(rnd_word());
    for (int c = 0; c < 9; c++) begin
      tick(!(c >= 3 && c <= 6), 1'b0, 1'b0);
      if (c == 3) held = obs_data;
      if (c >= 3 && c <= 7) begin
        vecs++; if (obs_lane !== 2) begin errs++; $display("FAIL bp_lane c%0d: got %0d want 2", c, obs_lane); end
        vecs++; if (obs_data !== exp_data || obs_data !== held) begin errs++; $display("FAIL bp_data c%0d: got %h want %h", c, obs_data, exp_data); end
      end
      if (c >= 3 && c <= 6) begin
        vecs++; if (obs_rden !== 1'b0) begin errs++; $display("FAIL bp_rden c%0d: got %b want 0", c, obs_rden); end
      end
      if (c == 8) begin
        vecs++; if (obs_lane !== 3 || obs_valid !== 1'b1) begin errs++; $display("FAIL bp_resume: got lane %0d valid %b want lane 3 valid 1", obs_lane, obs_valid); end
      end
    end
    drain();
  endtask

  task automatic test_empty_at_end();
    fq.push_back(rnd_word());
    for (int c = 0; c <= NL; c++) tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_last !== 1'b1) begin errs++; $display("FAIL eae_last: got %b want 1", obs_last); end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL eae_idle c%0d: got %b want 0", c, obs_valid); end
    end
    fq.push_back(rnd_word());
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_rden !== 1'b1) begin errs++; $display("FAIL eae_pop: got %b want 1", obs_rden); end
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b1 || obs_lane !== 0) begin errs++; $display("FAIL eae_start: got valid %b lane %0d want valid 1 lane 0", obs_valid, obs_lane); end
    vecs++; if (obs_data !== exp_data) begin errs++; $display("FAIL eae_data: got %h want %h", obs_data, exp_data); end
    drain();
  endtask

  task automatic test_flush();
    fq.push_back(rnd_word());
    fq.push_back(rnd_word());
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    vecs++; if (obs_lane !== 1 || obs_valid !== 1'b1) begin errs++; $display("FAIL flush_at: got lane %0d want 1", obs_lane); end
    vecs++; if (obs_rden !== 1'b0) begin errs++; $display("FAIL flush_rden: got %b want 0", obs_rden); end
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", obs_valid); end
    vecs++; if (obs_rden !== 1'b1) begin errs++; $display("FAIL flush_repop: got %b want 1", obs_rden); end
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b1 || obs_lane !== 0) begin errs++; $display("FAIL flush_next: got valid %b lane %0d want 1/0", obs_valid, obs_lane); end
    vecs++; if (obs_data !== exp_data) begin errs++; $display("FAIL flush_data: got %h want %h", obs_data, exp_data); end
    drain();
  endtask

  task automatic test_reset_mid_word();
    fq.push_back(rnd_word());
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    vecs++; if (obs_lane !== 3) begin errs++; $display("FAIL rstmid_at: got lane %0d want 3", obs_lane); end
    tick(1'b1, 1'b0, 1'b0);
    vecs++; if (obs_valid !== 1'b0 || obs_last !== 1'b0 || obs_rden !== 1'b0) begin errs++; $display("FAIL rstmid_ctrl: got valid %b last %b rden %b want 0", obs_valid, obs_last, obs_rden); end
    vecs++; if (obs_data !== '0 || obs_lane !== 0) begin errs++; $display("FAIL rstmid_data: got data %h lane %0d want 0", obs_data, obs_lane); end
  endtask

  task automatic test_random();
    bit rdy, fl, rs;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 6) fq.push_back(rnd_word());
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      rs  = ($urandom_range(0, 150) == 0);
      tick(rdy, fl, rs);
      vecs++; if (obs_valid !== exp_valid) begin errs++; $display("FAIL rnd_valid c%0d: got %b want %b", c, obs_valid, exp_valid); end
      vecs++; if (obs_rden !== exp_rden) begin errs++; $display("FAIL rnd_rden c%0d: got %b want %b", c, obs_rden, exp_rden); end
      if (exp_valid) begin
        vecs++; if (obs_data !== exp_data) begin errs++; $display("FAIL rnd_data c%0d: got %h want %h", c, obs_data, exp_data); end
        vecs++; if (obs_lane !== exp_lane) begin errs++; $display("FAIL rnd_lane c%0d: got %0d want %0d", c, obs_lane, exp_lane); end
        vecs++; if (obs_last !== exp_last) begin errs++; $display("FAIL rnd_last c%0d: got %b want %b", c, obs_last, exp_last); end
      end
    end
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    o_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd    = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_empty_at_end();
    test_flush();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
